// File: rtl/rsa_pkg.sv
// Shared RSA constants: operand width, default keys, command codes and FSM states.
// Used by both the encoder and the decoder so one bench can drive them back to back.
package rsa_pkg;

  localparam int unsigned RsaW = 13;

  // e=17, d=2753, n=3233 form a matching key pair.
  localparam int unsigned RsaEDefault = 17;
  localparam int unsigned RsaDDefault = 2753;
  localparam int unsigned RsaNDefault = 3233;

  localparam logic [2:0] CMD_NONE     = 3'd0;
  localparam logic [2:0] CMD_DATA     = 3'd1;
  localparam logic [2:0] CMD_LOAD_EXP = 3'd2;
  localparam logic [2:0] CMD_LOAD_MOD = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StReduce,
    StSquare,
    StMult,
    StFinish
  } rsa_state_e;

endpackage

// File: rtl/rsa_decoder_mod_mult.sv
// Bit-serial modular multiplier: p = a*b mod n, one bit of a per cycle, MSB first.
// Requires b < n and n >= 2; a is unrestricted.
module mod_mult #(
  parameter int unsigned W = 13
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] n_i,
  output logic [W-1:0] p_o,
  output logic         done_mm_o
);

  localparam int unsigned JW = $clog2(W);

  logic [W-1:0]  a_q, b_q, n_q, p_q;
  logic [JW-1:0] j_q;
  logic          run_q;
  logic [W:0]    p_dbl, p_red, p_add, p_step;

  // One extra bit is enough: every intermediate stays below 2n.
  always_comb begin
    p_dbl  = {p_q, 1'b0};
    p_red  = (p_dbl >= {1'b0, n_q}) ? p_dbl - {1'b0, n_q} : p_dbl;
    p_add  = a_q[j_q] ? p_red + {1'b0, b_q} : p_red;
    p_step = (p_add >= {1'b0, n_q}) ? p_add - {1'b0, n_q} : p_add;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      p_q   <= '0;
      j_q   <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      n_q   <= n_i;
      p_q   <= '0;
      j_q   <= JW'(W - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      p_q <= p_step[W-1:0];
      if (j_q == '0) begin
        run_q <= 1'b0;
      end else begin
        j_q <= j_q - 1'b1;
      end
    end
  end

  // The result is the final step value, valid in the cycle done_mm_o is high.
  assign p_o       = p_step[W-1:0];
  assign done_mm_o = run_q && (j_q == '0);

endmodule

// File: rtl/rsa_decoder.sv
// RSA decryptor: c^d mod n by left-to-right square-and-multiply over mod_mult.
// Holds the key registers, the command edge detector, the bit counter and the FSM.
module rsa_decoder
  import rsa_pkg::*;
#(
  parameter int unsigned W         = RsaW,
  parameter int unsigned D_DEFAULT = RsaDDefault,
  parameter int unsigned N_DEFAULT = RsaNDefault
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] data_i,
  input  logic [2:0]   input_data_type_i,
  output logic [15:0]  output_data_o,
  output logic         done_o,
  output logic         busy_o
);

  localparam int unsigned IW = $clog2(W);

  rsa_state_e    state_q, state_d;
  logic [2:0]    prev_cmd_q;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  rc_q, rc_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [IW-1:0] i_q, i_d;
  logic [15:0]   out_q, out_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          mm_start_q, mm_start_d;
  logic          mm_wait_q, mm_wait_d;

  logic          cmd_new;
  logic [W-1:0]  mm_a, mm_b, mm_p;
  logic          mm_done;

  mod_mult #(
    .W(W)
  ) u_mod_mult (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (mm_start_q),
    .a_i      (mm_a),
    .b_i      (mm_b),
    .n_i      (n_q),
    .p_o      (mm_p),
    .done_mm_o(mm_done)
  );

  // A held code acts once: only a change to a nonzero value counts.
  assign cmd_new = (input_data_type_i != CMD_NONE) && (input_data_type_i != prev_cmd_q);

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    n_d        = n_q;
    c_d        = c_q;
    rc_d       = rc_q;
    acc_d      = acc_q;
    i_d        = i_q;
    out_d      = out_q;
    done_d     = done_q;
    busy_d     = busy_q;
    mm_start_d = 1'b0;
    mm_wait_d  = mm_wait_q;
    mm_a       = acc_q;
    mm_b       = acc_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_new) begin
          case (input_data_type_i)
            CMD_DATA: begin
              c_d     = data_i;
              done_d  = 1'b0;
              state_d = StReduce;
            end
            CMD_LOAD_EXP: d_d = data_i;
            CMD_LOAD_MOD: begin
              if (data_i >= W'(2)) begin
                n_d = data_i;
              end
            end
            default: ;
          endcase
        end
      end

      StReduce, StSquare, StMult: begin
        busy_d = 1'b1;
        if (state_q == StReduce) begin
          mm_a = c_q;
          mm_b = W'(1);
        end else if (state_q == StMult) begin
          mm_b = rc_q;
        end
        // First cycle of each state issues the multiply; then wait for it.
        if (!mm_wait_q) begin
          mm_start_d = 1'b1;
          mm_wait_d  = 1'b1;
        end else if (mm_done) begin
          mm_wait_d = 1'b0;
          if (state_q == StReduce) begin
            rc_d    = mm_p;
            acc_d   = W'(1);
            i_d     = IW'(W - 1);
            state_d = StSquare;
          end else begin
            acc_d = mm_p;
            if (state_q == StSquare && d_q[i_q]) begin
              state_d = StMult;
            end else if (i_q == '0) begin
              state_d = StFinish;
            end else begin
              i_d     = i_q - 1'b1;
              state_d = StSquare;
            end
          end
        end
      end

      StFinish: begin
        out_d   = 16'(acc_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      prev_cmd_q <= CMD_NONE;
      d_q        <= W'(D_DEFAULT);
      n_q        <= W'(N_DEFAULT);
      c_q        <= '0;
      rc_q       <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      out_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_wait_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_cmd_q <= input_data_type_i;
      d_q        <= d_d;
      n_q        <= n_d;
      c_q        <= c_d;
      rc_q       <= rc_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      out_q      <= out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mm_start_q <= mm_start_d;
      mm_wait_q  <= mm_wait_d;
    end
  end

  assign output_data_o = out_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;

endmodule
